// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer preset front end.
package timer_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned NUM_BTNS   = 5;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned CUR_W      = 3;

  // Bit positions of the conditioned buttons inside the pulse vector
  localparam int unsigned BTN_DOWN   = 0;
  localparam int unsigned BTN_UP     = 1;
  localparam int unsigned BTN_RIGHT  = 2;
  localparam int unsigned BTN_LEFT   = 3;
  localparam int unsigned BTN_CENTER = 4;

  typedef enum logic [1:0] {
    ST_EDIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CUR_W-1:0] CUR_SEC1  = 3'd0;
  localparam logic [CUR_W-1:0] CUR_SEC10 = 3'd1;
  localparam logic [CUR_W-1:0] CUR_MIN1  = 3'd2;
  localparam logic [CUR_W-1:0] CUR_MIN10 = 3'd3;
  localparam logic [CUR_W-1:0] CUR_HR1   = 3'd4;
  localparam logic [CUR_W-1:0] CUR_HR10  = 3'd5;

  localparam logic [DIGIT_W-1:0] DIG_MAX_UNITS = 4'd9;
  localparam logic [DIGIT_W-1:0] DIG_MAX_TENS  = 4'd5;
  localparam logic [DIGIT_W-1:0] FILLER        = 4'hF;

  // Preset word as seen by the countdown display
  typedef struct packed {
    logic [DIGIT_W-1:0] hr_10;
    logic [DIGIT_W-1:0] hr_1;
    logic [DIGIT_W-1:0] fill_hm;
    logic [DIGIT_W-1:0] min_10;
    logic [DIGIT_W-1:0] min_1;
    logic [DIGIT_W-1:0] fill_ms;
    logic [DIGIT_W-1:0] sec_10;
    logic [DIGIT_W-1:0] sec_1;
  } preset_t;

  // Largest legal value of the digit at a cursor position
  function automatic logic [DIGIT_W-1:0] digit_max(input logic [CUR_W-1:0] idx);
    return (idx == CUR_SEC10 || idx == CUR_MIN10) ? DIG_MAX_TENS : DIG_MAX_UNITS;
  endfunction

  // Increment with wrap to zero past the digit's maximum
  function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d,
                                                   input logic [DIGIT_W-1:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

  // Decrement with wrap from zero to the digit's maximum
  function automatic logic [DIGIT_W-1:0] digit_dec(input logic [DIGIT_W-1:0] d,
                                                   input logic [DIGIT_W-1:0] max);
    return (d == 4'd0) ? max : d - 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces one raw push-button; emits a one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DB_CNT_W        = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync_q1;
  logic                sync_q2;
  logic [1:0]          vld_q;
  logic                armed_q;
  logic [DB_CNT_W-1:0] cnt_q;

  // Two-flop synchronizer; vld_q marks when sync_q2 carries a real sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      vld_q   <= {vld_q[0], 1'b1};
    end
  end

  // Accept a new level after a full stable window; pulse only once a release was seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      btn_pulse <= 1'b0;
      if (sync_q2 == btn_level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q     <= '0;
        btn_level <= sync_q2;
        btn_pulse <= sync_q2 & armed_q;
      end else begin
        cnt_q <= cnt_q + DB_CNT_W'(1);
      end
      if (vld_q[1] && !sync_q2) begin
        armed_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_preset_ctrl.sv
// Button-driven preset editor and run/abort/acknowledge control for the countdown.
module timer_preset_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DB_CNT_W        = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  input  logic        finish,
  output logic [31:0] preset,
  output logic        go,
  output logic [2:0]  cursor,
  output logic        editing
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_lvl;
  logic [NUM_BTNS-1:0] btn_pls;
  logic                unused_lvl;
  logic                fin_q1;
  logic                fin_s;
  state_t              state_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] dig_q;
  preset_t             preset_w;

  assign btn_raw = {btn_center, btn_left, btn_right, btn_up, btn_down};

  // One conditioner per push-button
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_CNT_W       (DB_CNT_W)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_raw[i]),
      .btn_level(btn_lvl[i]),
      .btn_pulse(btn_pls[i])
    );
  end

  // Stable levels are not needed here; only the press edges drive actions
  assign unused_lvl = ^btn_lvl;

  // finish comes from another timing domain; synchronize only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_q1 <= 1'b0;
      fin_s  <= 1'b0;
    end else begin
      fin_q1 <= finish;
      fin_s  <= fin_q1;
    end
  end

  // Edit/run/done control; one action per cycle with center > left > right > up > down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EDIT;
      dig_q   <= '0;
      cursor  <= CUR_SEC1;
      go      <= 1'b0;
      editing <= 1'b1;
    end else begin
      case (state_q)
        ST_EDIT: begin
          if (btn_pls[BTN_CENTER]) begin
            if (|dig_q) begin
              state_q <= ST_RUN;
              go      <= 1'b1;
              editing <= 1'b0;
            end
          end else if (btn_pls[BTN_LEFT]) begin
            cursor <= (cursor == CUR_HR10) ? CUR_SEC1 : cursor + 3'd1;
          end else if (btn_pls[BTN_RIGHT]) begin
            cursor <= (cursor == CUR_SEC1) ? CUR_HR10 : cursor - 3'd1;
          end else if (btn_pls[BTN_UP]) begin
            dig_q[cursor] <= digit_inc(dig_q[cursor], digit_max(cursor));
          end else if (btn_pls[BTN_DOWN]) begin
            dig_q[cursor] <= digit_dec(dig_q[cursor], digit_max(cursor));
          end
        end
        ST_RUN: begin
          if (btn_pls[BTN_CENTER]) begin
            state_q <= ST_EDIT;
            go      <= 1'b0;
            editing <= 1'b1;
          end else if (fin_s) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (btn_pls[BTN_CENTER]) begin
            state_q <= ST_EDIT;
            go      <= 1'b0;
            editing <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_EDIT;
          go      <= 1'b0;
          editing <= 1'b1;
        end
      endcase
    end
  end

  // Pack digits and fillers into the countdown's display word
  always_comb begin
    preset_w         = '0;
    preset_w.hr_10   = dig_q[CUR_HR10];
    preset_w.hr_1    = dig_q[CUR_HR1];
    preset_w.fill_hm = FILLER;
    preset_w.min_10  = dig_q[CUR_MIN10];
    preset_w.min_1   = dig_q[CUR_MIN1];
    preset_w.fill_ms = FILLER;
    preset_w.sec_10  = dig_q[CUR_SEC10];
    preset_w.sec_1   = dig_q[CUR_SEC1];
  end

  assign preset = preset_w;

endmodule

// File: tb/tb_timer_preset_ctrl.sv
// Scoreboard bench for timer_preset_ctrl with a short debounce window.
module tb_timer_preset_ctrl;

  localparam int unsigned DC = 4;
  localparam int unsigned CW = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_up, btn_down, btn_left, btn_right, btn_center, finish;
  logic [31:0] preset;
  logic        go;
  logic [2:0]  cursor;
  logic        editing;

  always #5 clk = ~clk;

  timer_preset_ctrl #(.DEBOUNCE_CYCLES(DC), .DB_CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_center(btn_center),
    .finish    (finish),
    .preset    (preset),
    .go        (go),
    .cursor    (cursor),
    .editing   (editing)
  );

  typedef struct {
    string       name;
    logic [31:0] preset;
    logic        go;
    logic [2:0]  cursor;
    logic        editing;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: six digits, a cursor and a mode (0 edit, 1 run, 2 done)
  int m_dig[6];
  int m_cur;
  int m_st;

  function automatic void model_reset();
    foreach (m_dig[i]) m_dig[i] = 0;
    m_cur = 0;
    m_st  = 0;
  endfunction

  function automatic logic [31:0] model_preset();
    logic [31:0] p;
    p = 32'h00F00F00;
    p[3:0]   = 4'(m_dig[0]);
    p[7:4]   = 4'(m_dig[1]);
    p[15:12] = 4'(m_dig[2]);
    p[19:16] = 4'(m_dig[3]);
    p[27:24] = 4'(m_dig[4]);
    p[31:28] = 4'(m_dig[5]);
    return p;
  endfunction

  // Mask bits: [4]=center [3]=left [2]=right [1]=up [0]=down
  function automatic void model_apply(input logic [4:0] m);
    bit any = 0;
    int lim;
    foreach (m_dig[i]) if (m_dig[i] != 0) any = 1;
    lim = (m_cur == 1 || m_cur == 3) ? 5 : 9;
    if (m[4]) begin
      if (m_st == 0) begin
        if (any) m_st = 1;
      end else begin
        m_st = 0;
      end
    end else if (m_st == 0) begin
      if (m[3])      m_cur = (m_cur + 1) % 6;
      else if (m[2]) m_cur = (m_cur + 5) % 6;
      else if (m[1]) m_dig[m_cur] = (m_dig[m_cur] + 1) % (lim + 1);
      else if (m[0]) m_dig[m_cur] = (m_dig[m_cur] + lim) % (lim + 1);
    end
  endfunction

  function automatic void expect_const(input string n, input logic [31:0] p,
                                       input logic g, input logic [2:0] c, input logic e);
    exp_t x;
    x.name = n; x.preset = p; x.go = g; x.cursor = c; x.editing = e;
    sb.push_back(x);
  endfunction

  function automatic void expect_model(input string n);
    expect_const(n, model_preset(), m_st != 0, 3'(m_cur), m_st == 0);
  endfunction

  function automatic void chk(input string n, input string f,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
    end
  endfunction

  // Monitor: compares DUT outputs against queued expectations away from the active edge
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, "preset",  preset,         e.preset);
      chk(e.name, "go",      32'(go),        32'(e.go));
      chk(e.name, "cursor",  32'(cursor),    32'(e.cursor));
      chk(e.name, "editing", 32'(editing),   32'(e.editing));
    end
  end

  task automatic drive(input logic [4:0] m);
    btn_center = m[4];
    btn_left   = m[3];
    btn_right  = m[2];
    btn_up     = m[1];
    btn_down   = m[0];
  endtask

  task automatic press(input logic [4:0] m, input int hold, input string n);
    @(posedge clk); #1;
    drive(m);
    repeat (hold) @(posedge clk);
    #1 drive(5'b0);
    repeat (DC + 6) @(posedge clk);
    #1;
    if (hold >= int'(DC)) model_apply(m);
    expect_model(n);
  endtask

  task automatic finish_pulse(input int len, input string n);
    @(posedge clk); #1;
    finish = 1'b1;
    repeat (len) @(posedge clk);
    #1 finish = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if (m_st == 1) m_st = 2;
    expect_model(n);
  endtask

  // Center press whose debounced pulse lands in the same cycle as a one-cycle fin_s
  task automatic center_finish_collide();
    @(posedge clk); #1;
    drive(5'b10000);
    repeat (4) @(posedge clk);
    #1 finish = 1'b1;
    @(posedge clk);
    #1 finish = 1'b0;
    repeat (3) @(posedge clk);
    #1 drive(5'b0);
    repeat (DC + 6) @(posedge clk);
    #1;
    model_apply(5'b10000);
    expect_model("collide_center_fin");
  endtask

  task automatic reset_mid(input string n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    model_reset();
    expect_const(n, 32'h00F00F00, 1'b0, 3'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] m;
    int         r;
    rst_n = 1'b0;
    finish = 1'b0;
    drive(5'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_const("reset", 32'h00F00F00, 1'b0, 3'd0, 1'b1);

    // Debounce: short glitch ignored, long hold yields exactly one step
    press(5'b00010, 3, "glitch_up");
    expect_const("glitch_const", 32'h00F00F00, 1'b0, 3'd0, 1'b1);
    press(5'b00010, 6, "up_held6");
    expect_const("up_held6_const", 32'h00F00F01, 1'b0, 3'd0, 1'b1);
    press(5'b00010, 20, "up_held20");
    press(5'b00001, 6, "down_a");
    press(5'b00001, 6, "down_b");

    // Digit and cursor wrap
    press(5'b01000, 6, "left_to1");
    press(5'b00001, 6, "sec10_down_wrap");
    expect_const("sec10_is5", 32'h00F00F50, 1'b0, 3'd1, 1'b1);
    press(5'b00010, 6, "sec10_up_wrap");
    press(5'b00100, 6, "right_to0");
    for (int i = 0; i < 10; i++) press(5'b00010, 6, "sec1_up_loop");
    expect_const("sec1_wrap10", 32'h00F00F00, 1'b0, 3'd0, 1'b1);
    press(5'b00100, 6, "right_wrap");
    expect_const("cursor_is5", 32'h00F00F00, 1'b0, 3'd5, 1'b1);
    press(5'b01000, 6, "left_wrap");

    // Start guard, then build 01:20:00 and run
    press(5'b10000, 6, "center_at_zero");
    press(5'b00100, 6, "cur5");
    press(5'b00100, 6, "cur4");
    press(5'b00010, 6, "hr1_up");
    press(5'b00100, 6, "cur3");
    press(5'b00010, 6, "min10_up1");
    press(5'b00010, 6, "min10_up2");
    expect_const("preset_012000", 32'h01F20F00, 1'b0, 3'd3, 1'b1);
    press(5'b10000, 6, "start_run");
    expect_const("run_const", 32'h01F20F00, 1'b1, 3'd3, 1'b0);
    press(5'b00010, 6, "up_in_run");

    // Finish and acknowledge
    finish_pulse(2, "finish_done");
    press(5'b00010, 6, "up_in_done");
    press(5'b10000, 6, "ack_done");
    expect_const("ack_const", 32'h01F20F00, 1'b0, 3'd3, 1'b1);

    // Collisions
    press(5'b10000, 6, "rerun");
    center_finish_collide();
    press(5'b01010, 6, "left_up_same");
    finish_pulse(3, "finish_in_edit");

    // Reset during run, and a button held across reset release
    press(5'b10000, 6, "run_before_rst");
    reset_mid("rst_in_run");
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(5'b00010);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (12) @(posedge clk);
    #1 drive(5'b0);
    repeat (DC + 6) @(posedge clk);
    #1 expect_model("held_through_reset");
    press(5'b00010, 6, "fresh_press_after_rst");

    // Randomized mix of presses, combos and finish pulses
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        finish_pulse(int'($urandom_range(1, 3)), "rnd_finish");
      end else begin
        if (r < 4) m = 5'($urandom_range(1, 31));
        else       m = 5'(1 << $urandom_range(0, 4));
        press(m, int'($urandom_range(DC + 1, DC + 8)), "rnd_press");
      end
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_preset_ctrl.md
Name: timer_preset_ctrl

Overview:
- Front end for the countdown timer. It turns five raw push-buttons into the packed BCD preset word and the go/run level that the countdown block consumes.
- Preset word format matches the countdown display word: {hr_10, hr_1, 4'hF, min_10, min_1, 4'hF, sec_10, sec_1}.
- The user edits the six digits with a cursor, starts the run, aborts it, and acknowledges the finish flag.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of clk cycles a synchronized button must stay stable before its level is accepted (10 ms at 100 MHz).
- DB_CNT_W, 20, width of each debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- btn_up  input  1  raw button: increment the digit under the cursor.
- btn_down  input  1  raw button: decrement the digit under the cursor.
- btn_left  input  1  raw button: move cursor toward hr_10.
- btn_right  input  1  raw button: move cursor toward sec_1.
- btn_center  input  1  raw button: start / abort / acknowledge.
- finish  input  1  countdown reached zero; asynchronous to this block's edit logic.
- preset  output  32  packed BCD preset (tmp1 of the countdown).
- go  output  1  run enable to the countdown.
- cursor  output  3  selected digit: 0=sec_1, 1=sec_10, 2=min_1, 3=min_10, 4=hr_1, 5=hr_10.
- editing  output  1  high in EDIT state (drives cursor blink on the display).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All flops clear immediately on rst_n=0.
- Reset values:
  - all digits 0, so preset = 32'h00F00F00;
  - go = 0, cursor = 0, editing = 1, state = EDIT;
  - sync/debounce flops 0.
- Input conditioning, per button and per finish:
  - 2-flop synchronizer.
  - Buttons then pass through a debouncer. Stable level is updated only after DEBOUNCE_CYCLES consecutive equal samples; the counter resets on any mismatch.
  - A one-cycle press pulse is generated on the stable level's 0->1 edge.
  - finish is synchronized only (no debounce), giving fin_s.
- Latency:
  - raw press held stable -> press pulse after 2 + DEBOUNCE_CYCLES cycles;
  - preset/cursor/go update on the clock edge after the pulse.
- Action priority, at most one action per cycle: center > left > right > up > down. Lower-priority pulses in the same cycle are dropped.
- Filler nibbles [23:20] and [11:8] are constant 4'hF.
- Digit ranges, with wrap:
  - sec_1, min_1, hr_1, hr_10: 0..9. Up from 9 -> 0; down from 0 -> 9.
  - sec_10, min_10: 0..5. Up from 5 -> 0; down from 0 -> 5.
  - Editing a digit never changes any other digit (no carry/borrow).
- Cursor movement: left increments cursor, 5 -> 0 wrap. Right decrements cursor, 0 -> 5 wrap.
- FSM:
  - EDIT (go=0, editing=1): left/right/up/down act as above.
    - center with all digits 0: ignored, stay EDIT.
    - center with any digit nonzero: -> RUN.
  - RUN (go=1, editing=0): edit buttons ignored; preset frozen.
    - center: -> EDIT (abort; go drops; countdown reloads preset).
    - fin_s=1: -> DONE.
    - If center and fin_s are both 1 in the same cycle, center wins -> EDIT.
  - DONE (go=1, editing=0): edit buttons ignored; go is held so the countdown stays at zero.
    - center: -> EDIT, with preset retained for a repeat run.
- fin_s while in EDIT is ignored.
- Reset asserted mid-RUN: immediate return to reset values. go=0 lets the countdown reload 00:00:00.
- Buttons already held when rst_n deasserts: no pulse until a release followed by a fresh press.

Decomposition:
- Shared package (timer_pkg):
  - state encoding ST_EDIT=0, ST_RUN=1, ST_DONE=2;
  - cursor index constants CUR_SEC1..CUR_HR10;
  - digit limit constants (9/5);
  - filler nibble 4'hF.
- Sub-module btn_debounce:
  - parameters DEBOUNCE_CYCLES, DB_CNT_W;
  - ports clk, rst_n, btn_raw -> btn_level, btn_pulse;
  - instantiated 5 times.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: rst_n=0 then 1 -> preset=32'h00F00F00, go=0, cursor=0, editing=1.
- Glitch rejection: btn_up high for 3 cycles -> no change. Held 6 cycles -> sec_1=1 (preset=32'h00F00F01), one increment only, until release and re-press.
- Digit wrap: cursor=1, down once -> sec_10=5. Up once -> 0. Cursor=0 pressed 10 ups -> sec_1 back to 0. Left from cursor 5 -> 0; right from 0 -> 5.
- Start guard and run:
  - center at all-zero -> stays EDIT, go=0;
  - set hr_1=1, min_10=2 -> preset=32'h01F20F00; center -> go=1, editing=0;
  - up pressed during RUN -> preset unchanged.
- Finish: in RUN drive finish=1 -> DONE after sync (3 cycles), go stays 1. Center -> EDIT, go=0, preset still 32'h01F20F00.
- Collisions/reset: center and finish pulse same cycle in RUN -> EDIT. Left+up simultaneous in EDIT -> cursor moves, digit unchanged. rst_n=0 during RUN -> go=0 asynchronously, preset=32'h00F00F00.
